// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for unified_mem_arbiter: CPU requester, debug requester and memory port.
// Defining MEM_ARB_LOCK_EN adds the dbg_lock signal.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
`ifdef MEM_ARB_LOCK_EN
    logic              dbg_lock;
`endif

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  dbg_lock,
`endif
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester/memory side
    modport master (
`ifdef MEM_ARB_LOCK_EN
        output dbg_lock,
`endif
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// CPU/debug arbiter for the single-ported unified memory: CPU priority with a debug
// starvation bound, fixed read latency. MEM_ARB_LOCK_EN adds dbg_lock (CPU lock-out).
module unified_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 4
) (
    input logic                  clk,
    input logic                  reset,
    unified_mem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, WAIT_RD} state_t;
    typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q;
    logic [2:0]        lat_cnt_q;
    logic [3:0]        burst_cnt_q;
    logic              cpu_rvalid_q, dbg_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

    logic              cpu_win, dbg_win, rd_issue, burst_full, cpu_block;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;

`ifdef MEM_ARB_LOCK_EN
    assign cpu_block = bus.dbg_lock;
`else
    assign cpu_block = 1'b0;
`endif

    assign burst_full = (burst_cnt_q == 4'(MAX_BURST));

    always_comb begin
        state_d = state_q;
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (state_q == IDLE && !reset) begin
            cpu_win = bus.cpu_req & ~cpu_block & ~(bus.dbg_req & burst_full);
            dbg_win = bus.dbg_req & ~cpu_win;
        end
        rd_issue = (cpu_win & ~bus.cpu_we) | (dbg_win & ~bus.dbg_we);
        case (state_q)
            IDLE:    if (rd_issue) state_d = WAIT_RD;
            WAIT_RD: if (lat_cnt_q == 3'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr_d  = bus.cpu_addr;
        mem_wdata_d = bus.cpu_wdata;
        mem_we_d    = cpu_win & bus.cpu_we;
        if (dbg_win) begin
            mem_addr_d  = bus.dbg_addr;
            mem_wdata_d = bus.dbg_wdata;
            mem_we_d    = bus.dbg_we;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            lat_cnt_q    <= '0;
            burst_cnt_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            if (state_q == IDLE) begin
                if (rd_issue) begin
                    lat_cnt_q <= 3'(MEM_LAT);
                    owner_q   <= dbg_win ? OWN_DBG : OWN_CPU;
                end
            end else begin
                lat_cnt_q <= lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    cpu_rvalid_q <= (owner_q == OWN_CPU);
                    dbg_rvalid_q <= (owner_q == OWN_DBG);
                end
            end
            // Starvation counter only tracks CPU wins while debug is actually waiting
            if (!bus.dbg_req || dbg_win)
                burst_cnt_q <= '0;
            else if (cpu_win && !burst_full)
                burst_cnt_q <= burst_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == WAIT_RD && lat_cnt_q == 3'd1) begin
            if (owner_q == OWN_CPU) cpu_rdata_q <= bus.mem_rdata;
            else                    dbg_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.cpu_gnt    = cpu_win;
    assign bus.dbg_gnt    = dbg_win;
    assign bus.mem_en     = cpu_win | dbg_win;
    assign bus.mem_we     = mem_we_d;
    assign bus.mem_addr   = mem_addr_d;
    assign bus.mem_wdata  = mem_wdata_d;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dbg_rdata  = dbg_rdata_q;

    // A granted CPU read keeps the core stalled from its grant cycle until rvalid
    assign bus.cpu_stall = ~reset & ((bus.cpu_req & ~cpu_win) | (cpu_win & ~bus.cpu_we) |
                                     (state_q == WAIT_RD && owner_q == OWN_CPU));
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=3,
// both MAX_BURST=4, sharing a simple latency-pipelined memory model.
module tb_unified_mem_arbiter;
    localparam logic [31:0] ONE  = 32'd1;
    localparam logic [31:0] ZERO = 32'd0;

    logic clk = 1'b0;
    logic reset;
    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_BURST(4)) dut1 (
        .clk(clk), .reset(reset), .bus(b1));
    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_BURST(4)) dut3 (
        .clk(clk), .reset(reset), .bus(b3));

    logic [31:0] mem [64];
    logic [31:0] p1;
    logic [31:0] p3 [3];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (b1.mem_en && b1.mem_we) mem[b1.mem_addr[7:2]] <= b1.mem_wdata;
        if (b3.mem_en && b3.mem_we) mem[b3.mem_addr[7:2]] <= b3.mem_wdata;
        p1    <= mem[b1.mem_addr[7:2]];
        p3[0] <= mem[b3.mem_addr[7:2]];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b1.mem_rdata = p1;
    assign b3.mem_rdata = p3[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_addr = '0; b1.cpu_wdata = '0;
        b1.dbg_req = 1'b0; b1.dbg_we = 1'b0; b1.dbg_addr = '0; b1.dbg_wdata = '0;
        b3.cpu_req = 1'b0; b3.cpu_we = 1'b0; b3.cpu_addr = '0; b3.cpu_wdata = '0;
        b3.dbg_req = 1'b0; b3.dbg_we = 1'b0; b3.dbg_addr = '0; b3.dbg_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
        b1.dbg_lock = 1'b0;
        b3.dbg_lock = 1'b0;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          ngr;
        int          lat;
        logic [5:0]  seq;
        logic        seen;
        logic        stall_seen;

        reset = 1'b1;
        idle_inputs();
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.dbg_req = 1'b1; b1.dbg_we = 1'b1;
        @(negedge clk);
        chk("rst_cpu_gnt",    32'(b1.cpu_gnt),    ZERO);
        chk("rst_dbg_gnt",    32'(b1.dbg_gnt),    ZERO);
        chk("rst_mem_en",     32'(b1.mem_en),     ZERO);
        chk("rst_mem_we",     32'(b1.mem_we),     ZERO);
        chk("rst_cpu_rvalid", 32'(b1.cpu_rvalid), ZERO);
        chk("rst_dbg_rvalid", 32'(b1.dbg_rvalid), ZERO);
        chk("rst_cpu_stall",  32'(b1.cpu_stall),  ZERO);
        cyc();
        reset = 1'b0;
        idle_inputs();

        // CPU write then read-back of 0x10
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_addr = 32'h10; b1.cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_gnt",       32'(b1.cpu_gnt),   ONE);
        chk("wr_mem_en",    32'(b1.mem_en),    ONE);
        chk("wr_mem_we",    32'(b1.mem_we),    ONE);
        chk("wr_mem_addr",  b1.mem_addr,       32'h10);
        chk("wr_mem_wdata", b1.mem_wdata,      32'hDEADBEEF);
        chk("wr_stall",     32'(b1.cpu_stall), ZERO);
        cyc();
        b1.cpu_we = 1'b0;
        @(negedge clk);
        chk("rd_gnt",    32'(b1.cpu_gnt),   ONE);
        chk("rd_mem_en", 32'(b1.mem_en),    ONE);
        chk("rd_mem_we", 32'(b1.mem_we),    ZERO);
        chk("rd_stall",  32'(b1.cpu_stall), ONE);
        cyc();
        b1.cpu_req = 1'b0;
        @(negedge clk);
        chk("rd_wait_mem_en", 32'(b1.mem_en),     ZERO);
        chk("rd_wait_stall",  32'(b1.cpu_stall),  ONE);
        chk("rd_wait_rvalid", 32'(b1.cpu_rvalid), ZERO);
        cyc();
        @(negedge clk);
        chk("rd_rvalid",     32'(b1.cpu_rvalid), ONE);
        chk("rd_rdata",      b1.cpu_rdata,       32'hDEADBEEF);
        chk("rd_stall_low",  32'(b1.cpu_stall),  ZERO);
        chk("rd_dbg_rvalid", 32'(b1.dbg_rvalid), ZERO);
        cyc();
        @(negedge clk);
        chk("rd_rvalid_1cyc", 32'(b1.cpu_rvalid), ZERO);
        cyc();

        // Back-to-back CPU writes
        for (int i = 0; i < 3; i++) begin
            b1.cpu_req = 1'b1; b1.cpu_we = 1'b1;
            b1.cpu_addr = 32'(i * 4); b1.cpu_wdata = 32'(32'hA0 + i * 4);
            @(negedge clk);
            chk("b2b_mem_en",   32'(b1.mem_en), ONE);
            chk("b2b_mem_addr", b1.mem_addr,    32'(i * 4));
            cyc();
        end
        b1.cpu_req = 1'b0;
        @(negedge clk);
        chk("b2b_done_mem_en", 32'(b1.mem_en),     ZERO);
        chk("b2b_no_rvalid",   32'(b1.cpu_rvalid), ZERO);
        cyc();

        // Continuous CPU and debug reads: expect C,C,C,C,D,C
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 32'h8;
        b1.dbg_req = 1'b1; b1.dbg_we = 1'b0; b1.dbg_addr = 32'h4;
        ngr = 0; seq = '0; seen = 1'b0;
        for (int i = 0; i < 40 && ngr < 6; i++) begin
            @(negedge clk);
            if (b1.dbg_rvalid) begin
                seen = 1'b1;
                chk("arb_dbg_rdata", b1.dbg_rdata, 32'hA4);
            end
            if (b1.cpu_rvalid) chk("arb_cpu_rdata", b1.cpu_rdata, 32'hA8);
            if (b1.cpu_gnt || b1.dbg_gnt) begin
                seq = {seq[4:0], b1.dbg_gnt};
                ngr++;
            end
            cyc();
        end
        chk("arb_grants",     32'(ngr),  32'd6);
        chk("arb_order",      32'(seq),  32'b000010);
        chk("arb_dbg_rvalid", 32'(seen), ONE);
        b1.cpu_req = 1'b0; b1.dbg_req = 1'b0;
        cyc(); cyc(); cyc();

        // Reset in the middle of a CPU read
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 32'h8;
        @(negedge clk);
        chk("mid_gnt", 32'(b1.cpu_gnt), ONE);
        cyc();
        reset = 1'b1;
        b1.dbg_req = 1'b1; b1.dbg_we = 1'b0; b1.dbg_addr = 32'h10;
        @(negedge clk);
        chk("mid_rst_cpu_gnt", 32'(b1.cpu_gnt),    ZERO);
        chk("mid_rst_dbg_gnt", 32'(b1.dbg_gnt),    ZERO);
        chk("mid_rst_mem_en",  32'(b1.mem_en),     ZERO);
        chk("mid_rst_mem_we",  32'(b1.mem_we),     ZERO);
        chk("mid_rst_stall",   32'(b1.cpu_stall),  ZERO);
        chk("mid_rst_rvalid",  32'(b1.cpu_rvalid), ZERO);
        cyc();
        @(negedge clk);
        chk("mid_rst_rvalid2", 32'(b1.cpu_rvalid), ZERO);
        cyc();
        reset = 1'b0;
        b1.cpu_req = 1'b0;
        @(negedge clk);
        chk("post_rst_dbg_gnt",  32'(b1.dbg_gnt),    ONE);
        chk("post_rst_mem_addr", b1.mem_addr,        32'h10);
        chk("post_rst_cpu_rv",   32'(b1.cpu_rvalid), ZERO);
        cyc();
        b1.dbg_req = 1'b0;
        @(negedge clk);
        chk("post_rst_wait", 32'(b1.dbg_rvalid), ZERO);
        cyc();
        @(negedge clk);
        chk("post_rst_dbg_rvalid", 32'(b1.dbg_rvalid), ONE);
        chk("post_rst_dbg_rdata",  b1.dbg_rdata,       32'hDEADBEEF);
        cyc();

        // MEM_LAT=3 debug write then read of 0x20
        b3.dbg_req = 1'b1; b3.dbg_we = 1'b1; b3.dbg_addr = 32'h20; b3.dbg_wdata = 32'h12345678;
        @(negedge clk);
        chk("l3_wr_gnt", 32'(b3.dbg_gnt), ONE);
        cyc();
        b3.dbg_we = 1'b0;
        @(negedge clk);
        chk("l3_rd_gnt", 32'(b3.dbg_gnt), ONE);
        stall_seen = b3.cpu_stall;
        cyc();
        b3.dbg_req = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge clk);
            if (b3.cpu_stall) stall_seen = 1'b1;
            if (b3.dbg_rvalid) begin
                lat = i;
                chk("l3_rdata", b3.dbg_rdata, 32'h12345678);
            end
            cyc();
        end
        chk("l3_latency", 32'(lat),        32'd4);
        chk("l3_no_stall", 32'(stall_seen), ZERO);

`ifdef MEM_ARB_LOCK_EN
        b1.dbg_lock = 1'b1;
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_addr = 32'h30; b1.cpu_wdata = 32'h1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("lock_cpu_gnt",   32'(b1.cpu_gnt),   ZERO);
            chk("lock_cpu_stall", 32'(b1.cpu_stall), ONE);
            cyc();
        end
        b1.dbg_lock = 1'b0;
        @(negedge clk);
        chk("unlock_cpu_gnt", 32'(b1.cpu_gnt), ONE);
        cyc();
        b1.cpu_req = 1'b0;
        cyc();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
